tx_chunk_arbiter: RTL and testbench

TX_CHUNK_ARBITER -- requirements
Module: tx_chunk_arbiter

---
 rtl/tx_chunk_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/tx_chunk_arbiter.sv | 118 +++++++++++
 tb/tb_tx_chunk_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_chunk_pkg.sv
// Shared definitions for the TX chunk arbiter: FSM encoding and chunk-type codes.
package tx_chunk_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SEND_TYPE    = 3'd1,
        SEND_SIZE    = 3'd2,
        SEND_PAYLOAD = 3'd3,
        ACK          = 3'd4,
        GAP          = 3'd5
    } state_t;

    // Chunk types; only text is defined, all other codes are reserved.
    localparam logic [7:0] CHUNK_TYPE_TEXT = 8'd5;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans from last_grant+1 (mod NUM_SOURCES)
// and returns the first requesting source.
module rr_priority_picker #(
    parameter int NUM_SOURCES = 2,
    parameter int GW          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [GW-1:0]          last_grant,
    output logic [GW-1:0]          grant,
    output logic                   any
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            if (!found && req[(int'(last_grant) + k) % NUM_SOURCES]) begin
                grant = GW'((int'(last_grant) + k) % NUM_SOURCES);
                found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/tx_chunk_arbiter.sv
// Serialises chunks (type, size, payload) from several requesters onto a byte
// stream, round-robin between sources, with a one-cycle ack per finished frame.
module tx_chunk_arbiter
    import tx_chunk_pkg::*;
#(
    parameter int NUM_SOURCES   = 2,
    parameter int PAYLOAD_BYTES = 32,
    parameter int SIZE_WIDTH    = 8
) (
    input  logic                                  CLK,
    input  logic                                  reset,
    input  logic [NUM_SOURCES-1:0]                req,
    input  logic [NUM_SOURCES*8-1:0]              req_type,
    input  logic [NUM_SOURCES*SIZE_WIDTH-1:0]     req_size,
    input  logic [NUM_SOURCES*PAYLOAD_BYTES*8-1:0] req_bytes,
    output logic [NUM_SOURCES-1:0]                ack,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy
);

    localparam int GW    = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);

    state_t                     state_q, state_d;
    logic [GW-1:0]              last_grant;
    logic [GW-1:0]              grant;
    logic                       any;
    logic [IDX_W-1:0]           byte_idx;
    logic [7:0]                 type_q;
    logic [IDX_W-1:0]           size_q;
    logic [PAYLOAD_BYTES*8-1:0] payload_q;
    logic                       xfer;
    logic                       last_byte;

    function automatic logic [IDX_W-1:0] clamp_size(input logic [SIZE_WIDTH-1:0] s);
        if (32'(s) > PAYLOAD_BYTES)
            return IDX_W'(PAYLOAD_BYTES);
        else
            return IDX_W'(s);
    endfunction

    rr_priority_picker #(
        .NUM_SOURCES (NUM_SOURCES),
        .GW          (GW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any)
    );

    assign xfer      = tx_valid && tx_ready;
    assign last_byte = (byte_idx == size_q - IDX_W'(1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            last_grant <= GW'(NUM_SOURCES - 1);
            byte_idx   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any)
                last_grant <= grant;
            if (state_q == IDLE)
                byte_idx <= '0;
            else if (state_q == SEND_PAYLOAD && xfer)
                byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
        end
    end

    // Snapshot of the winner; later changes on the request side cannot reach the frame.
    always_ff @(posedge CLK) begin
        if (state_q == IDLE && any) begin
            type_q    <= req_type[int'(grant)*8 +: 8];
            size_q    <= clamp_size(req_size[int'(grant)*SIZE_WIDTH +: SIZE_WIDTH]);
            payload_q <= req_bytes[int'(grant)*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8];
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (any)
                    state_d = SEND_TYPE;
            end
            SEND_TYPE: begin
                tx_valid = 1'b1;
                tx_data  = type_q;
                if (xfer)
                    state_d = SEND_SIZE;
            end
            SEND_SIZE: begin
                tx_valid = 1'b1;
                tx_data  = 8'(size_q);
                if (xfer)
                    state_d = (size_q != '0) ? SEND_PAYLOAD : ACK;
            end
            SEND_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = payload_q[{byte_idx, 3'b000} +: 8];
                if (xfer && last_byte)
                    state_d = ACK;
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ack  = (state_q == ACK) ? (NUM_SOURCES'(1) << last_grant) : '0;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tx_chunk_arbiter.sv
// Directed bench for tx_chunk_arbiter: frame contents, arbitration order,
// clamping, backpressure, mid-frame reset and snapshot isolation.
module tb_tx_chunk_arbiter;

    localparam int NS = 2;
    localparam int PB = 32;
    localparam int SW = 8;

    logic              CLK = 1'b0;
    logic              reset;
    logic [NS-1:0]     req;
    logic [NS*8-1:0]   req_type;
    logic [NS*SW-1:0]  req_size;
    logic [NS*PB*8-1:0] req_bytes;
    logic [NS-1:0]     ack;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         ack_src;
    int         ack_gap;

    tx_chunk_arbiter #(
        .NUM_SOURCES   (NS),
        .PAYLOAD_BYTES (PB),
        .SIZE_WIDTH    (SW)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req       (req),
        .req_type  (req_type),
        .req_size  (req_size),
        .req_bytes (req_bytes),
        .ack       (ack),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int s, input logic [7:0] t, input logic [7:0] sz,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        req_type[s*8 +: 8]   = t;
        req_size[s*SW +: SW] = sz;
        req_bytes[s*PB*8 +: PB*8] = '0;
        req_bytes[s*PB*8 +: 8]      = b0;
        req_bytes[s*PB*8 + 8 +: 8]  = b1;
        req_bytes[s*PB*8 + 16 +: 8] = b2;
    endtask

    // Runs from the current negedge until one ack is seen; returns at the GAP negedge.
    task automatic collect(input bit rnd, input int budget);
        bit         prev_hold = 1'b0;
        logic [7:0] prev_data = 8'h00;
        int         last_c = -1;
        bit         done = 1'b0;
        got_q.delete();
        ack_src = -1;
        ack_gap = -1;
        for (int c = 0; c < budget && !done; c++) begin
            if (prev_hold) begin
                check_eq("hold_valid", 32'(tx_valid), 32'd1);
                check_eq("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (ack != '0) begin
                ack_src = (ack == 2'b01) ? 0 : (ack == 2'b10) ? 1 : 9;
                ack_gap = c - last_c;
                check_eq("ack_valid_low", 32'(tx_valid), 32'd0);
                @(negedge CLK);
                check_eq("ack_one_cycle", 32'(ack), 32'd0);
                check_eq("gap_valid_low", 32'(tx_valid), 32'd0);
                done = 1'b1;
            end else begin
                tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    last_c = c;
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
                @(negedge CLK);
            end
        end
        if (!done)
            check_eq("collect_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int src);
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_ack_src"}, 32'(ack_src), 32'(src));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_type  = '0;
        req_size  = '0;
        req_bytes = '0;
        tx_ready  = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Basic frame, one-cycle latency, ack right after the last byte
        set_src(0, 8'h05, 8'd3, 8'h41, 8'h42, 8'h43);
        set_src(1, 8'h05, 8'd2, 8'h58, 8'h59, 8'h00);
        @(negedge CLK);
        req = 2'b01;
        @(negedge CLK);
        check_eq("latency_valid", 32'(tx_valid), 32'd1);
        check_eq("latency_data", 32'(tx_data), 32'h05);
        check_eq("latency_busy", 32'(busy), 32'd1);
        collect(1'b0, 100);
        req = '0;
        exp_q = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43};
        check_frame("basic", 0);
        check_eq("basic_ack_gap", 32'(ack_gap), 32'd1);
        repeat (2) @(negedge CLK);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Round-robin from reset, then again with last_grant=1
        do_reset();
        req = 2'b11;
        collect(1'b0, 100);
        check_frame("rr1", 0);
        req = 2'b10;
        collect(1'b0, 100);
        req = '0;
        exp_q = '{8'h05, 8'h02, 8'h58, 8'h59};
        check_frame("rr2", 1);
        repeat (2) @(negedge CLK);
        req = 2'b11;
        collect(1'b0, 100);
        req = 2'b10;
        exp_q = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43};
        check_frame("rr3", 0);
        collect(1'b0, 100);
        req = '0;
        exp_q = '{8'h05, 8'h02, 8'h58, 8'h59};
        check_frame("rr4", 1);

        // Zero-length payload
        set_src(0, 8'h05, 8'd0, 8'h41, 8'h42, 8'h43);
        @(negedge CLK);
        req = 2'b01;
        collect(1'b0, 100);
        req = '0;
        exp_q = '{8'h05, 8'h00};
        check_frame("size0", 0);

        // Oversize request is clamped to PAYLOAD_BYTES
        set_src(0, 8'h05, 8'd40, 8'h00, 8'h00, 8'h00);
        exp_q = '{8'h05, 8'h20};
        for (int k = 0; k < PB; k++) begin
            req_bytes[k*8 +: 8] = 8'(k + 8'h10);
            exp_q.push_back(8'(k + 8'h10));
        end
        @(negedge CLK);
        req = 2'b01;
        collect(1'b0, 200);
        req = '0;
        check_frame("clamp", 0);

        // Random backpressure
        set_src(0, 8'h05, 8'd3, 8'h41, 8'h42, 8'h43);
        @(negedge CLK);
        req = 2'b01;
        collect(1'b1, 400);
        req = '0;
        exp_q = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43};
        check_frame("bp", 0);

        // Reset while payload byte 1 is on the bus
        repeat (2) @(negedge CLK);
        tx_ready = 1'b1;
        req = 2'b01;
        @(negedge CLK);
        check_eq("rstmid_type", 32'(tx_data), 32'h05);
        @(negedge CLK);
        check_eq("rstmid_size", 32'(tx_data), 32'h03);
        @(negedge CLK);
        check_eq("rstmid_b0", 32'(tx_data), 32'h41);
        @(negedge CLK);
        check_eq("rstmid_b1", 32'(tx_data), 32'h42);
        tx_ready = 1'b0;
        reset = 1'b1;
        @(negedge CLK);
        check_eq("rstmid_valid", 32'(tx_valid), 32'd0);
        check_eq("rstmid_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        collect(1'b0, 100);
        req = '0;
        check_frame("rstmid_resend", 0);

        // Snapshot isolation, plus a request from source 1 arriving mid-frame
        @(negedge CLK);
        req = 2'b01;
        @(negedge CLK);
        set_src(0, 8'h07, 8'd1, 8'h78, 8'h79, 8'h7A);
        req = 2'b11;
        collect(1'b0, 100);
        req = 2'b10;
        check_frame("snap", 0);
        collect(1'b0, 100);
        req = '0;
        exp_q = '{8'h05, 8'h02, 8'h58, 8'h59};
        check_frame("late_req", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
